// File: rtl/top_system_io_bridge.sv
// Bridge between the tagged external memory read bus and the chip input streams,
// with bandwidth counters. Define BW_CNT_SATURATE_EN for saturating counters.
module top_system_io_bridge #(
    parameter int unsigned MEM_BW         = 128,
    parameter int unsigned NB_IN_STREAMS  = 3,
    parameter int unsigned NB_OUT_STREAMS = 2,
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned CNT_WIDTH      = 32,
    localparam int unsigned ID_W = (NB_IN_STREAMS > 1) ? $clog2(NB_IN_STREAMS) : 1
) (
    input  logic                               clk,
    input  logic                               arst_n_in,
    input  logic [MEM_BW-1:0]                  ext_data,
    input  logic [ID_W-1:0]                    ext_id,
    input  logic                               ext_valid,
    output logic                               ext_ready,
    output logic [NB_IN_STREAMS*MEM_BW-1:0]    chip_data,
    output logic [NB_IN_STREAMS-1:0]           chip_valid,
    input  logic [NB_IN_STREAMS-1:0]           chip_ready,
    input  logic [NB_OUT_STREAMS-1:0]          chip_out_valid,
    input  logic                               running,
    input  logic                               cnt_clear,
    output logic [NB_IN_STREAMS*CNT_WIDTH-1:0] in_beats,
    output logic [NB_OUT_STREAMS*CNT_WIDTH-1:0] out_beats,
    output logic [CNT_WIDTH-1:0]               active_cycles,
    output logic                               id_err,
    output logic                               overflow
);

    localparam int unsigned AddrW  = $clog2(FIFO_DEPTH);
    localparam int unsigned PtrW   = AddrW + 1;
    localparam int unsigned NumCnt = NB_IN_STREAMS + NB_OUT_STREAMS + 1;
    localparam logic [CNT_WIDTH-1:0] CntMax = '1;

    logic [PtrW-1:0]   wr_ptr_q [NB_IN_STREAMS];
    logic [PtrW-1:0]   wr_ptr_d [NB_IN_STREAMS];
    logic [PtrW-1:0]   rd_ptr_q [NB_IN_STREAMS];
    logic [PtrW-1:0]   rd_ptr_d [NB_IN_STREAMS];
    logic [MEM_BW-1:0] mem_q    [NB_IN_STREAMS][FIFO_DEPTH];

    logic [NB_IN_STREAMS-1:0] full, empty, push, pop;
    logic                     id_valid, sel_full;

    logic [CNT_WIDTH-1:0] cnt_q [NumCnt];
    logic [CNT_WIDTH-1:0] cnt_d [NumCnt];
    logic [NumCnt-1:0]    inc;
    logic                 ovf_evt;
    logic                 id_err_q, id_err_d;
    logic                 overflow_q, overflow_d;

    assign id_valid = 32'(ext_id) < NB_IN_STREAMS;

    always_comb begin
        sel_full = 1'b0;
        for (int i = 0; i < NB_IN_STREAMS; i++) begin
            empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
            full[i]  = (wr_ptr_q[i][PtrW-1] != rd_ptr_q[i][PtrW-1]) &&
                       (wr_ptr_q[i][AddrW-1:0] == rd_ptr_q[i][AddrW-1:0]);
            if (ext_id == ID_W'(i)) sel_full = full[i];
        end
    end

    // Unknown tags are always accepted so they drain from the shared bus.
    assign ext_ready  = !id_valid || !sel_full;
    assign chip_valid = ~empty;
    assign pop        = chip_valid & chip_ready;

    always_comb begin
        push      = '0;
        chip_data = '0;
        for (int i = 0; i < NB_IN_STREAMS; i++) begin
            push[i]     = ext_valid && ext_ready && (ext_id == ID_W'(i));
            wr_ptr_d[i] = wr_ptr_q[i] + PtrW'(push[i]);
            rd_ptr_d[i] = rd_ptr_q[i] + PtrW'(pop[i]);
            chip_data[i*MEM_BW +: MEM_BW] = mem_q[i][rd_ptr_q[i][AddrW-1:0]];
        end
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int i = 0; i < NB_IN_STREAMS; i++) begin
                wr_ptr_q[i] <= '0;
                rd_ptr_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NB_IN_STREAMS; i++) begin
                wr_ptr_q[i] <= wr_ptr_d[i];
                rd_ptr_q[i] <= rd_ptr_d[i];
            end
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NB_IN_STREAMS; i++) begin
            if (push[i]) mem_q[i][wr_ptr_q[i][AddrW-1:0]] <= ext_data;
        end
    end

    // Counter order: in-stream pops, then output strobes, then active cycles.
    assign inc = {running, chip_out_valid, pop};

    always_comb begin
        ovf_evt = 1'b0;
        for (int k = 0; k < NumCnt; k++) begin
            cnt_d[k] = cnt_q[k];
            if (inc[k]) begin
`ifdef BW_CNT_SATURATE_EN
                if (cnt_q[k] != CntMax) cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                if (cnt_d[k] == CntMax) ovf_evt = 1'b1;
`else
                cnt_d[k] = cnt_q[k] + CNT_WIDTH'(1);
                if (cnt_q[k] == CntMax) ovf_evt = 1'b1;
`endif
            end
            if (cnt_clear) cnt_d[k] = '0;
        end
        overflow_d = cnt_clear ? 1'b0 : (overflow_q | ovf_evt);
        id_err_d   = cnt_clear ? 1'b0 : (id_err_q | (ext_valid && !id_valid));
    end

    always_ff @(posedge clk or negedge arst_n_in) begin
        if (!arst_n_in) begin
            for (int k = 0; k < NumCnt; k++) cnt_q[k] <= '0;
            id_err_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            for (int k = 0; k < NumCnt; k++) cnt_q[k] <= cnt_d[k];
            id_err_q   <= id_err_d;
            overflow_q <= overflow_d;
        end
    end

    always_comb begin
        in_beats  = '0;
        out_beats = '0;
        for (int i = 0; i < NB_IN_STREAMS; i++) begin
            in_beats[i*CNT_WIDTH +: CNT_WIDTH] = cnt_q[i];
        end
        for (int j = 0; j < NB_OUT_STREAMS; j++) begin
            out_beats[j*CNT_WIDTH +: CNT_WIDTH] = cnt_q[NB_IN_STREAMS + j];
        end
    end

    assign active_cycles = cnt_q[NumCnt-1];
    assign id_err        = id_err_q;
    assign overflow      = overflow_q;

endmodule

// File: tb/tb_top_system_io_bridge.sv
// Directed bench for top_system_io_bridge: queue-based reference model checked every cycle,
// plus hand-computed spot checks.
module tb_top_system_io_bridge;

    localparam int N_IN  = 3;
    localparam int N_OUT = 2;
    localparam int DEPTH = 4;
    localparam int BW    = 128;
    localparam int CW    = 8;
    localparam int IDW   = 2;
    localparam int unsigned MAXC = (1 << CW) - 1;

    logic                 clk = 1'b0;
    logic                 arst_n_in = 1'b0;
    logic [BW-1:0]        ext_data = '0;
    logic [IDW-1:0]       ext_id = '0;
    logic                 ext_valid = 1'b0;
    logic                 ext_ready;
    logic [N_IN*BW-1:0]   chip_data;
    logic [N_IN-1:0]      chip_valid;
    logic [N_IN-1:0]      chip_ready = '0;
    logic [N_OUT-1:0]     chip_out_valid = '0;
    logic                 running = 1'b0;
    logic                 cnt_clear = 1'b0;
    logic [N_IN*CW-1:0]   in_beats;
    logic [N_OUT*CW-1:0]  out_beats;
    logic [CW-1:0]        active_cycles;
    logic                 id_err;
    logic                 overflow;

    int n_tests = 0;
    int n_fail  = 0;

    top_system_io_bridge #(
        .MEM_BW        (BW),
        .NB_IN_STREAMS (N_IN),
        .NB_OUT_STREAMS(N_OUT),
        .FIFO_DEPTH    (DEPTH),
        .CNT_WIDTH     (CW)
    ) u_dut (
        .clk           (clk),
        .arst_n_in     (arst_n_in),
        .ext_data      (ext_data),
        .ext_id        (ext_id),
        .ext_valid     (ext_valid),
        .ext_ready     (ext_ready),
        .chip_data     (chip_data),
        .chip_valid    (chip_valid),
        .chip_ready    (chip_ready),
        .chip_out_valid(chip_out_valid),
        .running       (running),
        .cnt_clear     (cnt_clear),
        .in_beats      (in_beats),
        .out_beats     (out_beats),
        .active_cycles (active_cycles),
        .id_err        (id_err),
        .overflow      (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: one queue per stream and plain integer counters.
    logic [BW-1:0] q_m [N_IN][$];
    int unsigned   in_m [N_IN];
    int unsigned   out_m [N_OUT];
    int unsigned   act_m;
    bit            ovf_m, ide_m;

    task automatic bump(inout int unsigned c);
`ifdef BW_CNT_SATURATE_EN
        c = (c + 1 > MAXC) ? MAXC : c + 1;
        if (c == MAXC) ovf_m = 1'b1;
`else
        if (c + 1 > MAXC) ovf_m = 1'b1;
        c = (c + 1) % (MAXC + 1);
`endif
    endtask

    always @(negedge clk) begin
        int unsigned sz [N_IN];
        int          id;
        if (!arst_n_in) begin
            for (int i = 0; i < N_IN; i++) begin q_m[i].delete(); in_m[i] = 0; end
            for (int j = 0; j < N_OUT; j++) out_m[j] = 0;
            act_m = 0; ovf_m = 1'b0; ide_m = 1'b0;
        end
        id = int'(ext_id);
        for (int i = 0; i < N_IN; i++) begin
            chk($sformatf("chip_valid[%0d]", i), 128'(chip_valid[i]), 128'(q_m[i].size() != 0));
            if (q_m[i].size() != 0)
                chk($sformatf("chip_data[%0d]", i), chip_data[i*BW +: BW], q_m[i][0]);
            chk($sformatf("in_beats[%0d]", i), 128'(in_beats[i*CW +: CW]), 128'(in_m[i]));
        end
        for (int j = 0; j < N_OUT; j++)
            chk($sformatf("out_beats[%0d]", j), 128'(out_beats[j*CW +: CW]), 128'(out_m[j]));
        chk("ext_ready", 128'(ext_ready), 128'((id >= N_IN) || (q_m[id].size() < DEPTH)));
        chk("active_cycles", 128'(active_cycles), 128'(act_m));
        chk("id_err", 128'(id_err), 128'(ide_m));
        chk("overflow", 128'(overflow), 128'(ovf_m));
        if (arst_n_in) begin
            for (int i = 0; i < N_IN; i++) sz[i] = q_m[i].size();
            for (int i = 0; i < N_IN; i++) begin
                if (sz[i] != 0 && chip_ready[i]) begin
                    void'(q_m[i].pop_front());
                    if (!cnt_clear) bump(in_m[i]);
                end
            end
            if (ext_valid && id < N_IN && sz[id] < DEPTH) q_m[id].push_back(ext_data);
            if (cnt_clear) begin
                for (int i = 0; i < N_IN; i++) in_m[i] = 0;
                for (int j = 0; j < N_OUT; j++) out_m[j] = 0;
                act_m = 0; ovf_m = 1'b0; ide_m = 1'b0;
            end else begin
                for (int j = 0; j < N_OUT; j++) if (chip_out_valid[j]) bump(out_m[j]);
                if (running) bump(act_m);
                if (ext_valid && id >= N_IN) ide_m = 1'b1;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input int id, input logic [BW-1:0] d);
        ext_valid = 1'b1;
        ext_id    = IDW'(id);
        ext_data  = d;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 arst_n_in = 1'b1;
        chk("reset_chip_valid", 128'(chip_valid), 128'(0));
        chk("reset_active", 128'(active_cycles), 128'(0));

        // One beat per stream, chip always ready.
        chip_ready = 3'b111;
        beat(0, 128'hA0); step();
        chk("lat_valid0", 128'(chip_valid[0]), 128'(1));
        chk("lat_data0", chip_data[0 +: BW], 128'hA0);
        beat(1, 128'hB1); step();
        chk("lat_data1", chip_data[BW +: BW], 128'hB1);
        beat(2, 128'hC2); step();
        chk("lat_data2", chip_data[2*BW +: BW], 128'hC2);
        ext_valid = 1'b0;
        repeat (3) step();
        for (int i = 0; i < N_IN; i++)
            chk($sformatf("in_beats_one[%0d]", i), 128'(in_beats[i*CW +: CW]), 128'(1));

        // Fill stream 1 while its chip side stalls.
        chip_ready = 3'b101;
        for (int k = 0; k < 4; k++) begin beat(1, 128'h10 + 128'(k)); step(); end
        beat(1, 128'h14); #1;
        chk("full_backpressure", 128'(ext_ready), 128'(0));
        beat(0, 128'h20); #1;
        chk("other_stream_free", 128'(ext_ready), 128'(1));
        step();
        beat(1, 128'h14); chip_ready = 3'b111; #1;
        chk("full_no_bypass", 128'(ext_ready), 128'(0));
        step();
        chk("slot_freed", 128'(ext_ready), 128'(1));
        chk("order_head", chip_data[BW +: BW], 128'h11);
        step();
        ext_valid = 1'b0;
        repeat (6) step();
        chk("in_beats1_total", 128'(in_beats[CW +: CW]), 128'(6));
        chk("in_beats0_total", 128'(in_beats[0 +: CW]), 128'(2));

        // Unknown tag is swallowed and flagged.
        beat(3, 128'hDEAD); #1;
        chk("bad_id_ready", 128'(ext_ready), 128'(1));
        step();
        ext_valid = 1'b0; #1;
        chk("id_err_set", 128'(id_err), 128'(1));
        chk("bad_id_no_valid", 128'(chip_valid), 128'(0));
        cnt_clear = 1'b1; step(); cnt_clear = 1'b0;
        chk("id_err_clear", 128'(id_err), 128'(0));
        chk("in_beats_clear", 128'(in_beats[CW +: CW]), 128'(0));

        // Running and output-strobe accounting.
        for (int k = 0; k < 100; k++) begin
            running = 1'b1;
            chip_out_valid = (k < 40) ? 2'b01 : 2'b00;
            step();
        end
        running = 1'b0; chip_out_valid = '0;
        chk("active_100", 128'(active_cycles), 128'(100));
        chk("out_beats0_40", 128'(out_beats[0 +: CW]), 128'(40));
        chk("out_beats1_0", 128'(out_beats[CW +: CW]), 128'(0));
        running = 1'b1; chip_out_valid = 2'b10; cnt_clear = 1'b1; step();
        running = 1'b0; chip_out_valid = '0; cnt_clear = 1'b0;
        chk("clear_wins_active", 128'(active_cycles), 128'(0));
        chk("clear_wins_out", 128'(out_beats[CW +: CW]), 128'(0));

        // Push MAXC+2 beats through stream 0 to cross the counter limit.
        for (int k = 0; k < int'(MAXC) + 2; k++) begin beat(0, 128'(k)); step(); end
        ext_valid = 1'b0;
        repeat (3) step();
`ifdef BW_CNT_SATURATE_EN
        chk("in_beats0_limit", 128'(in_beats[0 +: CW]), 128'(MAXC));
`else
        chk("in_beats0_limit", 128'(in_beats[0 +: CW]), 128'(1));
`endif
        chk("overflow_sticky", 128'(overflow), 128'(1));

        // Reset with beats buffered.
        chip_ready = 3'b000;
        running = 1'b1;
        beat(2, 128'h31); step();
        beat(2, 128'h32); step();
        ext_valid = 1'b0; running = 1'b0;
        chk("buffered_before_rst", 128'(chip_valid[2]), 128'(1));
        arst_n_in = 1'b0; #1;
        chk("rst_chip_valid", 128'(chip_valid), 128'(0));
        chk("rst_in_beats0", 128'(in_beats[0 +: CW]), 128'(0));
        chk("rst_active", 128'(active_cycles), 128'(0));
        chk("rst_overflow", 128'(overflow), 128'(0));
        step(); step();
        arst_n_in = 1'b1;
        chip_ready = 3'b111;
        step(); step();
        chk("post_rst_empty", 128'(chip_valid), 128'(0));
        chk("post_rst_in_beats2", 128'(in_beats[2*CW +: CW]), 128'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/top_system_io_bridge.md
Name: top_system_io_bridge

Overview:
- Parametrised successor to the system-level wrapper boundary.
- Sits between the external memory and top_chip.
- Demultiplexes one shared, tagged external memory read bus into NB_IN_STREAMS per-stream FIFOs that feed the chip inputs (activations, masks, weights, ...).
- Counts every beat crossing the chip boundary in both directions, plus running cycles, for bandwidth accounting.

Parameters:
- MEM_BW, 128: data width of external bus and of each chip input stream.
- NB_IN_STREAMS, 3: number of chip input streams; must be at least 1.
- NB_OUT_STREAMS, 2: number of chip output valid strobes counted.
- FIFO_DEPTH, 4: entries per input-stream FIFO; power of 2, at least 2.
- CNT_WIDTH, 32: width of every bandwidth counter.
- ID_W, max(1,$clog2(NB_IN_STREAMS)): width of the stream tag. Derived, not overridable.

Ports:
- clk  in  1  system clock.
- arst_n_in  in  1  asynchronous reset, active low.
- ext_data  in  MEM_BW  external memory beat.
- ext_id  in  ID_W  destination stream of ext_data.
- ext_valid  in  1  external beat valid.
- ext_ready  out  1  bridge accepts beat.
- chip_data  out  NB_IN_STREAMS*MEM_BW  stream i on [i*MEM_BW +: MEM_BW].
- chip_valid  out  NB_IN_STREAMS  per-stream valid to chip.
- chip_ready  in  NB_IN_STREAMS  per-stream ready from chip.
- chip_out_valid  in  NB_OUT_STREAMS  chip output-beat strobes (encoded, masks, ...).
- running  in  1  chip running flag.
- cnt_clear  in  1  synchronous clear of counters and sticky flags.
- in_beats  out  NB_IN_STREAMS*CNT_WIDTH  per-stream accepted-by-chip beat count.
- out_beats  out  NB_OUT_STREAMS*CNT_WIDTH  per-output beat count.
- active_cycles  out  CNT_WIDTH  cycles with running=1.
- id_err  out  1  sticky: beat with ext_id >= NB_IN_STREAMS seen.
- overflow  out  1  sticky: any counter reached/passed its maximum.

Behaviour:
- Reset (async assert, sync deassert handled upstream): all FIFOs empty; all counters 0; id_err=0; overflow=0; chip_valid=0.
- ext_ready is combinational:
  - valid id: !full[ext_id];
  - invalid id: 1, so the beat is consumed and dropped, and id_err is set next cycle.
- Push to FIFO[ext_id] on ext_valid && ext_ready && valid id.
- chip_valid[i] = !empty[i]. chip_data slice i = FIFO[i] head, stable while chip_valid[i] && !chip_ready[i].
- Pop on chip_valid[i] && chip_ready[i].
- Latency: beat accepted in cycle N is presented to chip in cycle N+1. There is no combinational bypass.
- Full FIFO: ext_ready=0 for that id even if the same-cycle pop frees a slot. No push at full.
- Empty FIFO with same-cycle push: the entry becomes visible next cycle.
- Simultaneous push and pop on a non-full, non-empty FIFO: occupancy unchanged, order preserved.
- Streams are independent. A full stream never blocks beats tagged for other streams; backpressure is only on the current ext_id.
- Pointers are log2(FIFO_DEPTH)+1 bits; full/empty are derived from the MSB and the equality compare. Pointers wrap naturally.
- Counters:
  - in_beats[i] +1 per chip-side pop of stream i;
  - out_beats[j] +1 per cycle chip_out_valid[j]=1;
  - active_cycles +1 per cycle running=1.
- cnt_clear=1: all counters, id_err and overflow go to 0 next cycle. Clear wins over a same-cycle increment or error. FIFOs are untouched.
- Reset mid-transfer: FIFO contents are discarded and outputs return to reset values immediately.

Optional Feature:
- Macro BW_CNT_SATURATE_EN.
- Defined: each counter holds at 2^CNT_WIDTH-1 once reached; overflow sets when any counter reaches max.
- Undefined: counters wrap to 0; overflow sets on any wrap.
- overflow is sticky in both cases until cnt_clear or reset.

Test Plan:
- Reset, then 3 beats with ext_id=0,1,2 and data 0xA0/0xB1/0xC2, chip_ready=all 1 -> each chip_valid pulses 1 cycle after acceptance with matching data; in_beats={1,1,1}.
- chip_ready[1]=0, push 5 beats to id 1 (FIFO_DEPTH=4) -> ext_ready=0 on 5th; interleaved id 0 beats still accepted; release ready -> 4 beats in order, then 5th.
- ext_id=3 with NB_IN_STREAMS=3 -> ext_ready=1, no chip_valid, id_err=1 next cycle; cnt_clear -> id_err=0.
- running=1 for 100 cycles, chip_out_valid=2'b01 for 40 -> active_cycles=100, out_beats={0,40}; cnt_clear in the same cycle as an increment -> 0.
- CNT_WIDTH=4, 17 pops on stream 0 -> with BW_CNT_SATURATE_EN: in_beats[0]=15, overflow=1; without: in_beats[0]=1, overflow=1.
- Assert arst_n_in low with 2 beats buffered -> chip_valid=0 immediately, counters 0, after release FIFO empty.
